pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush controller for an N-stage, multi-lane pipeline.
//  Stage 0 is the front (fetch1); a higher index is deeper.
//  A stall or flush requested by stage k acts on every stage in front of it (stages 0..k-1).
//  Adds three things beyond a plain stall unit: any depth and lane count, flush with priority over stall,
//  and a minimum stall hold to stop stall thrash. Also counts stall cycles for performance monitoring.
// PARAMETERS
//  NUM_STAGES  8   number of pipeline stages (>=2)
//  LANES       2   parallel lanes per stage (>=1)
//  MIN_HOLD    2   minimum consecutive cycles stall_o stays asserted once raised (>=1)
//  CNT_W       16  width of the stall-cycle counter
// PORTS
//  clock_i       in   1                single clock, rising edge
//  reset_i       in   1                synchronous, active-high
//  stallReq_i    in   NUM_STAGES*LANES stall request; lane l of stage s is bit s*LANES+l
//  flushReq_i    in   NUM_STAGES       flush request, one bit per stage
//  stall_o       out  NUM_STAGES       registered stall, one bit per stage
//  flush_o       out  NUM_STAGES       registered one-cycle flush pulse, one bit per stage
//  state_o       out  2                FSM state: 0 RUN, 1 STALL, 2 FLUSH
//  stallCycles_o out  CNT_W            saturating count of cycles with stall_o[0]=1
// BEHAVIOUR
//  - All outputs are registered. They reflect inputs sampled at the previous rising edge (1-cycle latency).
//  - Reset: state=RUN, stall_o=0, flush_o=0, holdCnt=0, stallCycles_o=0. A reset in the middle of a stall or
//    flush overrides everything on that edge.
//  - Requests from stage 0 are ignored: there is nothing in front of it.
//  - sDeep = highest stage s>=1 with any lane bit set in stallReq_i. fDeep = the same for flushReq_i.
//  - mask(k) = the bits for stages 0..k-1 set, all others clear. Bit NUM_STAGES-1 of each output is always 0.
//  - Flush outranks stall. When several stages request, the deepest one wins.
//  - RUN state: stall_o=0, flush_o=0.
//      On a flush request: go to FLUSH, flush_o<=mask(fDeep).
//      Else on a stall request: go to STALL, stall_o<=mask(sDeep), holdCnt<=MIN_HOLD-1.
//  - STALL state:
//      On a flush request: go to FLUSH, flush_o<=mask(fDeep), stall_o<=0, holdCnt<=0 (hold cancelled).
//      Else on a stall request: stall_o<=mask(sDeep). The mask can grow or shrink; holdCnt decrements if >0.
//      Else if holdCnt>0: keep stall_o, holdCnt--.
//      Else: go to RUN, stall_o<=0.
//  - FLUSH state: lasts exactly one cycle with stall_o=0. Next edge applies the RUN rules to current inputs,
//    so a second flush or a stall is taken immediately.
//  - stallCycles_o: increments on each edge where stall_o[0] is 1 before the edge.
//    Saturates at all-ones and does not wrap.
//  - MIN_HOLD=1 gives plain 1-cycle-latency stall following: no hold extension.
// TESTING
//  1. Reset held 3 cycles with random requests -> every output stays 0 and state_o=0 throughout.
//  2. NUM_STAGES=8, LANES=2, MIN_HOLD=2. One-cycle pulse on stallReq_i bit 9 (stage 4, lane 1) ->
//     stall_o=8'h0F for exactly 2 cycles starting 1 cycle later, then 0; stallCycles_o=2.
//  3. Stage 2 and stage 5 stall together for 4 cycles -> stall_o=8'h1F for 4 cycles.
//     Stage 5 then drops while stage 2 holds -> stall_o=8'h03.
//  4. During a stall at stage 4, pulse flushReq_i[6] -> next cycle flush_o=8'h3F, stall_o=0, state_o=2.
//     Following cycle: stall_o=8'h0F if the stage 4 request persists.
//  5. Stage 0 only, stall and flush requests -> all outputs stay 0 and state_o stays RUN.
//  6. CNT_W=4, stage 3 stalls for 20 cycles -> stallCycles_o saturates at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for a multi-lane pipeline. The deepest requester wins,
// flush outranks stall, and a raised stall is held for a minimum number of cycles.
module pipeline_hazard_ctrl #(
    parameter int NUM_STAGES = 8,
    parameter int LANES      = 2,
    parameter int MIN_HOLD   = 2,
    parameter int CNT_W      = 16
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic [NUM_STAGES*LANES-1:0] stallReq_i,
    input  logic [NUM_STAGES-1:0]       flushReq_i,
    output logic [NUM_STAGES-1:0]       stall_o,
    output logic [NUM_STAGES-1:0]       flush_o,
    output logic [1:0]                  state_o,
    output logic [CNT_W-1:0]            stallCycles_o
);

    localparam int SW = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1;
    localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD + 1) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [NUM_STAGES-1:0]   stall_reg, stall_next;
    logic [NUM_STAGES-1:0]   flush_reg, flush_next;
    logic [HW-1:0]           hold_reg, hold_next;
    logic [CNT_W-1:0]        cnt_reg;

    logic [NUM_STAGES-1:1]   stage_stall;
    logic [SW-1:0]           s_deep, f_deep;
    logic                    s_any, f_any;

    // Stage 0 has nothing in front of it, so its requests never matter.
    logic unused_stage0;
    assign unused_stage0 = ^{stallReq_i[LANES-1:0], flushReq_i[0]};

    genvar gi;
    generate
        for (gi = 1; gi < NUM_STAGES; gi++) begin : g_stage_or
            assign stage_stall[gi] = |stallReq_i[gi*LANES +: LANES];
        end
    endgenerate

    // Ascending scan: the last hit is the deepest requesting stage.
    always_comb begin
        s_deep = '0;
        f_deep = '0;
        s_any  = 1'b0;
        f_any  = 1'b0;
        for (int s = 1; s < NUM_STAGES; s++) begin
            if (stage_stall[s]) begin
                s_deep = SW'(s);
                s_any  = 1'b1;
            end
            if (flushReq_i[s]) begin
                f_deep = SW'(s);
                f_any  = 1'b1;
            end
        end
    end

    function automatic logic [NUM_STAGES-1:0] mask_of(input logic [SW-1:0] k);
        logic [NUM_STAGES-1:0] m;
        for (int i = 0; i < NUM_STAGES; i++) begin
            m[i] = (i < int'(k));
        end
        return m;
    endfunction

    always_comb begin
        state_next = state_reg;
        stall_next = stall_reg;
        flush_next = '0;
        hold_next  = hold_reg;
        case (state_reg)
            STALL: begin
                if (f_any) begin
                    state_next = FLUSH;
                    flush_next = mask_of(f_deep);
                    stall_next = '0;
                    hold_next  = '0;
                end else if (s_any) begin
                    stall_next = mask_of(s_deep);
                    if (hold_reg != '0) begin
                        hold_next = hold_reg - 1'b1;
                    end
                end else if (hold_reg != '0) begin
                    hold_next = hold_reg - 1'b1;
                end else begin
                    state_next = RUN;
                    stall_next = '0;
                end
            end
            // FLUSH lasts one cycle and then behaves exactly like RUN.
            default: begin
                stall_next = '0;
                hold_next  = '0;
                state_next = RUN;
                if (f_any) begin
                    state_next = FLUSH;
                    flush_next = mask_of(f_deep);
                end else if (s_any) begin
                    state_next = STALL;
                    stall_next = mask_of(s_deep);
                    hold_next  = HW'(MIN_HOLD - 1);
                end
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_reg <= RUN;
            stall_reg <= '0;
            flush_reg <= '0;
            hold_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            stall_reg <= stall_next;
            flush_reg <= flush_next;
            hold_reg  <= hold_next;
            if (stall_reg[0] && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign stall_o       = stall_reg;
    assign flush_o       = flush_reg;
    assign state_o       = state_reg;
    assign stallCycles_o = cnt_reg;

endmodule
